// File: rtl/muldiv_seq.sv
// Sequential 32-bit MUL / DIVU / REMU unit that borrows a shared ALU for its add/subtract steps.
// Optional MULDIV_EARLY_OUT_EN: MUL finishes once the remaining multiplier bits are zero.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result
);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] opa;   // multiplicand (shifts left) or dividend (shifts left)
  logic [31:0] opb;   // multiplier (shifts right) or divisor (fixed)
  logic [31:0] acc;   // product accumulator or partial remainder
  logic [30:0] quot;
  logic [4:0]  cnt;

  logic [32:0] r;
  logic        ge;
  logic [31:0] acc_n;
  logic [31:0] quot_n;
  logic        fin;
  logic [31:0] fin_val;

  always_comb begin
    r           = {acc, opa[31]};
    ge          = (r >= {1'b0, opb});
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    if (state == S_RUN) begin
      if (op_q == OP_MUL) begin
        alu_a = acc;
        alu_b = opb[0] ? opa : '0;
      end else begin
        alu_control = ALU_SUB;
        alu_a       = r[31:0];
        alu_b       = opb;
      end
    end
    acc_n  = (op_q == OP_MUL || ge) ? alu_result : r[31:0];
    quot_n = {quot, ge};
    fin    = (cnt == 5'd31);
`ifdef MULDIV_EARLY_OUT_EN
    if (op_q == OP_MUL && opb[31:1] == 31'd0) fin = 1'b1;
`endif
    fin_val = (op_q == OP_DIVU) ? quot_n : acc_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= OP_MUL;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      quot   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q <= op;
            opa  <= a;
            opb  <= b;
            acc  <= '0;
            quot <= '0;
            cnt  <= '0;
            // Degenerate cases resolve without touching the ALU.
            if (op == OP_RSV) begin
              result <= '0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (op != OP_MUL && b == 32'd0) begin
              result <= (op == OP_DIVU) ? 32'hFFFF_FFFF : a;
              done   <= 1'b1;
              state  <= S_DONE;
            end
`ifdef MULDIV_EARLY_OUT_EN
            else if (op == OP_MUL && (a == 32'd0 || b == 32'd0)) begin
              result <= '0;
              done   <= 1'b1;
              state  <= S_DONE;
            end
`endif
            else begin
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc  <= acc_n;
          quot <= quot_n[30:0];
          opa  <= opa << 1;
          opb  <= (op_q == OP_MUL) ? (opb >> 1) : opb;
          cnt  <= cnt + 5'd1;
          if (fin) begin
            result <= fin_val;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Random + directed bench for muldiv_seq against an arithmetic reference model; the bench also plays the shared ALU.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign alu_result = (alu_control == 4'b0001) ? alu_a - alu_b : alu_a + alu_b;

  muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x * y;
      2'b01:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      2'b10:   return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  // Clock edges from the start-sampling edge to the edge at which done is seen high.
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o == 2'b11) return 1;
    if (o != 2'b00 && y == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (o == 2'b00) begin
      if (x == 0 || y == 0) return 1;
      for (int i = 31; i >= 0; i--) if (y[i]) return i + 2;
    end
`endif
    return 33;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit poke);
    int lat, nbusy, elat;
    bit seen, alu_bad;
    elat = ref_lat(o, x, y);
    lat = 0; nbusy = 0; seen = 0; alu_bad = 0;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      else if (alu_a != 0 || alu_b != 0 || alu_control != 0) alu_bad = 1;
      if (done) begin
        seen = 1;
        lat = k;
      end
      start = (poke && k == 5);
      if (poke && k == 5) begin
        op = 2'b11; a = 32'd1; b = 32'd1;
      end
    end
    start = 1'b0;
    if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
    chk({tag, " result"}, result, ref_res(o, x, y));
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " busy cycles"}, 32'(nbusy), 32'(elat - 1));
    chk({tag, " alu idle"}, 32'(alu_bad), 32'd0);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'd0);
    chk({tag, " result held"}, result, ref_res(o, x, y));
  endtask

  initial begin
    logic [1:0] o;
    logic [31:0] x, y;
    bit saw_done;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset alu_a", alu_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul 7*6", 2'b00, 32'd7, 32'd6, 1'b1);
    run_op("mul ff*ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("remu 100/7", 2'b10, 32'd100, 32'd7, 1'b0);
    run_op("divu big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_op("remu big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_op("divu by0", 2'b01, 32'd5, 32'd0, 1'b0);
    run_op("remu by0", 2'b10, 32'd5, 32'd0, 1'b0);
    run_op("reserved", 2'b11, 32'd9, 32'd9, 1'b0);
    run_op("mul 9*3", 2'b00, 32'd9, 32'd3, 1'b0);
    run_op("mul 0*5", 2'b00, 32'd0, 32'd5, 1'b0);
    run_op("divu x/1", 2'b01, 32'hDEAD_BEEF, 32'd1, 1'b0);

    // Abort a multiply mid-flight; no done may escape and state must clear at once.
    @(negedge clk);
    op = 2'b00; a = 32'd1234; b = 32'd5678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", result, 32'd0);
    saw_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("abort no done", 32'(saw_done), 32'd0);
    run_op("mul 3*4 post-reset", 2'b00, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        default: y = $urandom;
      endcase
      run_op($sformatf("rnd%0d op%0d", i, o), o, x, y, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
